// File: rtl/dc_offset_remover_pkg.sv
// Shared Q1.15 definitions for the DSP chain (mean, offset removal, filters).
// Holds the format constants and the common 17-to-16 bit saturation helper.
package dc_offset_remover_pkg;

    localparam int DATA_W_DEF = 16;

    localparam logic [15:0] Q15_MAX = 16'h7FFF;
    localparam logic [15:0] Q15_MIN = 16'h8000;

    typedef struct packed {
        logic        sat;
        logic [15:0] value;
    } q15_sat_t;

    // Overflow out of Q1.15 shows up as a mismatch of the two top bits.
    function automatic q15_sat_t sat_q15(input logic signed [16:0] x);
        q15_sat_t r;
        r.sat   = x[16] ^ x[15];
        r.value = x[15:0];
        if (r.sat) begin
            r.value = x[16] ? Q15_MIN : Q15_MAX;
        end
        return r;
    endfunction

endpackage

// File: rtl/dc_offset_remover_pipe_stage.sv
// Single valid/ready register slice with a parameterised payload.
// Loads whenever it is empty or its consumer is taking the held word.
module dc_offset_remover_pipe_stage #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/dc_offset_remover.sv
// Subtracts the latest mean estimate from a Q1.15 sample stream,
// saturating the result; two-stage valid/ready pipeline.
module dc_offset_remover
    import dc_offset_remover_pkg::*;
#(
    parameter int DATA_W            = DATA_W_DEF,
    parameter bit BLOCK_UNTIL_VALID = 1'b1,
    parameter int SAT_CNT_W         = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_axis_mean_tvalid,
    output logic                 s_axis_mean_tready,
    input  logic [DATA_W-1:0]    mean_in,
    input  logic                 s_axis_data_tvalid,
    output logic                 s_axis_data_tready,
    input  logic [DATA_W-1:0]    data_in,
    output logic                 m_axis_data_tvalid,
    input  logic                 m_axis_data_tready,
    output logic [DATA_W-1:0]    data_out,
    output logic                 offset_valid,
    output logic [SAT_CNT_W-1:0] sat_count
);

    localparam int DW = DATA_W + 1;

    localparam logic [DATA_W-1:0] S_MAX =
        {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] S_MIN =
        {1'b1, {(DATA_W-1){1'b0}}};

    logic [DATA_W-1:0] offset;
    logic              mean_hs;
    logic              gate;

    logic              s1_in_valid;
    logic              s1_ready;
    logic [DW-1:0]     s1_in;
    logic              s1_valid;
    logic [DW-1:0]     s1_data;

    logic              s2_ready;
    logic              sat_in;
    logic [DATA_W-1:0] sat_val;
    logic              sat_q;

    assign s_axis_mean_tready = !rst;
    assign mean_hs = s_axis_mean_tvalid && s_axis_mean_tready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            offset       <= '0;
            offset_valid <= 1'b0;
        end else if (mean_hs) begin
            offset       <= mean_in;
            offset_valid <= 1'b1;
        end
    end

    assign gate = offset_valid || !BLOCK_UNTIL_VALID;
    assign s_axis_data_tready = s1_ready && gate;
    assign s1_in_valid = s_axis_data_tvalid && gate;

    // Offset register updates at the edge, so a same-cycle sample sees the old one.
    assign s1_in = {data_in[DATA_W-1], data_in}
                 - {offset[DATA_W-1], offset};

    dc_offset_remover_pipe_stage #(.W(DW)) u_stage1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s1_in_valid),
        .in_ready  (s1_ready),
        .in_data   (s1_in),
        .out_valid (s1_valid),
        .out_ready (s2_ready),
        .out_data  (s1_data)
    );

    always_comb begin
        sat_in  = s1_data[DW-1] ^ s1_data[DW-2];
        sat_val = s1_data[DATA_W-1:0];
        if (sat_in) begin
            sat_val = s1_data[DW-1] ? S_MIN : S_MAX;
        end
    end

    dc_offset_remover_pipe_stage #(.W(DATA_W+1)) u_stage2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s1_valid),
        .in_ready  (s2_ready),
        .in_data   ({sat_in, sat_val}),
        .out_valid (m_axis_data_tvalid),
        .out_ready (m_axis_data_tready),
        .out_data  ({sat_q, data_out})
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_count <= '0;
        end else if (m_axis_data_tvalid && m_axis_data_tready
                     && sat_q && (sat_count != '1)) begin
            sat_count <= sat_count + 1'b1;
        end
    end

endmodule

// File: doc/dc_offset_remover.md
Name: dc_offset_remover

Overview:
- Sits directly downstream of the mean stage and consumes its Q1.15 mean result as a DC offset estimate.
- Subtracts the currently held offset from every sample of a parallel Q1.15 sample stream, with saturation, and emits the DC-free stream.
- Both inputs and the output are AXI-Stream-style valid/ready channels.
- A new mean result replaces the held offset. All following samples use the new offset; samples already accepted are not affected.

Parameters:
- DATA_W, 16: sample/offset width, Q1.15 signed two's complement.
- BLOCK_UNTIL_VALID, 1: 1 = hold s_axis_data_tready low until the first offset has been loaded; 0 = pass samples through with offset 0 before the first load.
- SAT_CNT_W, 16: width of the saturation event counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- s_axis_mean_tvalid  in  1  mean result valid (from mean stage m_axis_data_tvalid).
- s_axis_mean_tready  out  1  offset channel ready.
- mean_in  in  DATA_W  mean value, Q1.15 (from mean stage sum_out).
- s_axis_data_tvalid  in  1  input sample valid.
- s_axis_data_tready  out  1  input sample ready.
- data_in  in  DATA_W  input sample, Q1.15.
- m_axis_data_tvalid  out  1  output sample valid.
- m_axis_data_tready  in  1  downstream ready.
- data_out  out  DATA_W  data_in minus offset, saturated, Q1.15.
- offset_valid  out  1  high once at least one offset has been loaded.
- sat_count  out  SAT_CNT_W  number of saturated output samples.

Behaviour:
- Reset (asynchronous, active-high) clears everything to zero:
  - offset register = 0x0000, offset_valid = 0.
  - Both pipeline valid flags = 0, so m_axis_data_tvalid = 0.
  - data_out = 0x0000, sat_count = 0.
  - s_axis_mean_tready = 0 while rst is high.
- Reset mid-stream: in-flight samples are dropped; no partial output follows deassertion.
- Offset channel:
  - s_axis_mean_tready = 1 whenever rst is low.
  - On the mean handshake the offset register loads mean_in and offset_valid sets; it stays set until reset.
- Data channel:
  - s_axis_data_tready = stage1_ready AND (offset_valid OR BLOCK_UNTIL_VALID==0).
  - BLOCK_UNTIL_VALID=1: tready first rises in the cycle after the first mean handshake.
- Simultaneous mean and data handshake in the same cycle: the sample uses the OLD offset. The new offset applies from the next accepted sample onward.
- Pipeline, two register stages with per-stage ready:
  - Stage 1: diff = sign_extend(data_in) - sign_extend(offset), 17-bit signed, registered.
  - Stage 2: saturate diff to DATA_W. diff > 0x7FFF gives 0x7FFF; diff < -0x8000 gives 0x8000; otherwise the low 16 bits. Result registered to data_out together with a sat flag.
  - Stage ready: stage_n_ready = !valid_n OR next_ready, with stage 2's next_ready = m_axis_data_tready.
  - Each stage loads when it is ready; its valid follows the upstream valid at that point.
- Latency: 2 cycles from input handshake to m_axis_data_tvalid, given no backpressure.
- Throughput: 1 sample/cycle. No bubbles when m_axis_data_tready is held high.
- Output hold:
  - While m_axis_data_tvalid=1 and m_axis_data_tready=0, data_out is held stable.
  - At most 2 samples are buffered; s_axis_data_tready drops when both stages are full.
- sat_count:
  - Increments by 1 at each output handshake whose sample saturated.
  - Sticks at its maximum value (all ones) and does not wrap.
- Boundary: offset 0x8000 and data 0x7FFF gives diff = 0xFFFF (17-bit), which saturates to 0x7FFF.

Decomposition:
- Shared package holds:
  - Q1.15 constants: Q15_MAX = 16'h7FFF, Q15_MIN = 16'h8000.
  - The DATA_W default.
  - A saturate-to-Q1.15 function (17-bit signed in, 16-bit out, plus a sat flag), which the mean and filter stages also use.
- One natural sub-module: pipe_stage, a valid/ready register slice with a parameterised payload width, instantiated twice (stage 1 and stage 2).

Test Plan:
- Reset:
  - Stimulus: assert rst with inputs active.
  - Response: m_axis_data_tvalid=0, data_out=0x0000, offset_valid=0, sat_count=0 within the same cycle (asynchronous).
- Blocking until first offset (BLOCK_UNTIL_VALID=1):
  - Stimulus: data_tvalid=1, data 0x6000, no mean.
  - Response: tready stays 0. After mean 0x4000 loads, tready=1 the next cycle; output 0x2000 two cycles after the data handshake.
- Saturation:
  - Stimulus: offset 0xC000 (-0.5), data 0x7000.
  - Response: 0x7FFF, sat_count=1. Then offset 0x4000, data 0x8000 gives 0x8000, sat_count=2. Then data 0x4000 gives 0x0000, sat_count stays 2.
- Simultaneous update:
  - Stimulus: offset 0x1000; in the same cycle, data 0x3000 and mean 0x2000 handshake; next data 0x3000.
  - Response: outputs 0x2000 then 0x1000.
- Backpressure:
  - Stimulus: 64-sample ramp 0x0000..0x003F with offset 0x0001; m_axis_data_tready random, ~50%.
  - Response: outputs exactly 0xFFFF..0x003E in order, no drop or duplicate; data_out stable while stalled; tready drops after 2 buffered samples.
- Reset mid-stream:
  - Stimulus: rst pulse while both stages are full.
  - Response: no output after release until new data is accepted; offset_valid=0, and data is blocked again (BLOCK_UNTIL_VALID=1).
